// File: rtl/l2cache_control_nway.sv
// Control FSM for a WAYS-way write-back L2 cache with tree PLRU and retry back-off.
// Define PERF_CNT_EN to add saturating hit/miss/write-back counters.
module l2cache_control_nway #(
    parameter int WAYS = 4,
    parameter int RTY_GAP = 4,
    localparam int WIDX = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_cyc,
    input  logic            cpu_stb,
    input  logic            cpu_we,
    output logic            cpu_ack,
    input  logic [WAYS-1:0] hit_vec,
    input  logic [WAYS-1:0] valid_vec,
    input  logic            victim_dirty,
    input  logic [WAYS-2:0] plru_out,
    output logic [WAYS-2:0] plru_in,
    output logic            plru_write,
    output logic [WIDX-1:0] victim_way,
    output logic [WAYS-1:0] way_write,
    output logic [WAYS-1:0] valid_write,
    output logic            valid_in,
    output logic [WAYS-1:0] dirty_write,
    output logic            dirty_in,
    output logic [1:0]      datainmux_sel,
    output logic            memaddrmux_sel,
    output logic            mem_cyc,
    output logic            mem_stb,
    output logic            mem_we,
    input  logic            mem_ack,
    input  logic            mem_rty
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count,
    output logic [31:0]     wb_count
`endif
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WRITE_BACK = 3'd1;
    localparam logic [2:0] STROBE     = 3'd2;
    localparam logic [2:0] ALLOCATE   = 3'd3;
    localparam logic [2:0] RTY_WAIT   = 3'd4;

    logic [2:0]      state, state_next;
    logic [2:0]      saved, saved_next;
    logic [7:0]      rty_cnt, rty_cnt_next;
    logic [WIDX-1:0] hit_way, inv_way, victim_sel;
    logic            req, any_hit, any_inv, hit_ev, miss_ev;

    // Point every node on the accessed way's path away from that way.
    function automatic logic [WAYS-2:0] plru_touch(
        input logic [WAYS-2:0] cur,
        input logic [WIDX-1:0] w
    );
        logic [WAYS-2:0] r;
        int n;
        r = cur;
        n = 0;
        for (int l = WIDX - 1; l >= 0; l--) begin
            r[n] = ~w[l];
            n = 2 * n + 1 + int'(w[l]);
        end
        return r;
    endfunction

    function automatic logic [WIDX-1:0] plru_walk(input logic [WAYS-2:0] t);
        logic [WIDX-1:0] v;
        int n;
        v = '0;
        n = 0;
        for (int l = WIDX - 1; l >= 0; l--) begin
            v[l] = t[n];
            n = 2 * n + 1 + int'(t[n]);
        end
        return v;
    endfunction

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WIDX'(i);
            if (!valid_vec[i]) inv_way = WIDX'(i);
        end
    end

    assign req        = cpu_cyc & cpu_stb;
    assign any_hit    = |hit_vec;
    assign any_inv    = ~&valid_vec;
    assign victim_sel = any_inv ? inv_way : plru_walk(plru_out);
    assign hit_ev     = (state == IDLE) && req && any_hit;
    assign miss_ev    = (state == IDLE) && req && !any_hit;

    always_comb begin
        state_next   = state;
        saved_next   = saved;
        rty_cnt_next = rty_cnt;
        case (state)
            IDLE: begin
                if (miss_ev) begin
                    if (valid_vec[victim_sel] && victim_dirty) state_next = WRITE_BACK;
                    else state_next = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_ack) begin
                    state_next = STROBE;
                end else if (mem_rty) begin
                    state_next   = RTY_WAIT;
                    saved_next   = WRITE_BACK;
                    rty_cnt_next = '0;
                end
            end
            STROBE: state_next = ALLOCATE;
            ALLOCATE: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end else if (mem_rty) begin
                    state_next   = RTY_WAIT;
                    saved_next   = ALLOCATE;
                    rty_cnt_next = '0;
                end
            end
            RTY_WAIT: begin
                if (rty_cnt == 8'(RTY_GAP - 1)) begin
                    state_next   = saved;
                    rty_cnt_next = '0;
                end else begin
                    rty_cnt_next = rty_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            saved      <= ALLOCATE;
            rty_cnt    <= '0;
            victim_way <= '0;
        end else begin
            state   <= state_next;
            saved   <= saved_next;
            rty_cnt <= rty_cnt_next;
            if (miss_ev) victim_way <= victim_sel;
        end
    end

    always_comb begin
        cpu_ack        = 1'b0;
        plru_in        = '0;
        plru_write     = 1'b0;
        way_write      = '0;
        valid_write    = '0;
        valid_in       = 1'b0;
        dirty_write    = '0;
        dirty_in       = 1'b0;
        datainmux_sel  = 2'b00;
        memaddrmux_sel = 1'b0;
        mem_cyc        = 1'b0;
        mem_stb        = 1'b0;
        mem_we         = 1'b0;
        case (state)
            IDLE: begin
                if (hit_ev) begin
                    cpu_ack    = 1'b1;
                    plru_write = 1'b1;
                    plru_in    = plru_touch(plru_out, hit_way);
                    if (cpu_we) begin
                        way_write     = WAYS'(1) << hit_way;
                        valid_write   = WAYS'(1) << hit_way;
                        dirty_write   = WAYS'(1) << hit_way;
                        valid_in      = 1'b1;
                        dirty_in      = 1'b1;
                        datainmux_sel = 2'b01;
                    end
                end
            end
            WRITE_BACK: begin
                mem_cyc        = 1'b1;
                mem_stb        = 1'b1;
                mem_we         = 1'b1;
                memaddrmux_sel = 1'b1;
            end
            ALLOCATE: begin
                mem_cyc = 1'b1;
                mem_stb = 1'b1;
                if (mem_ack) begin
                    way_write   = WAYS'(1) << victim_way;
                    valid_write = WAYS'(1) << victim_way;
                    dirty_write = WAYS'(1) << victim_way;
                    valid_in    = 1'b1;
                    plru_write  = 1'b1;
                    plru_in     = plru_touch(plru_out, victim_way);
                end
            end
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    logic wb_ev;
    assign wb_ev = (state == WRITE_BACK) && mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_ev && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (miss_ev && miss_count != '1) miss_count <= miss_count + 32'd1;
            if (wb_ev && wb_count != '1) wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2cache_control_nway.sv
// Randomised bench for l2cache_control_nway (4-way main instance, 8-way PLRU instance).
module tb_l2cache_control_nway;

    localparam int W = 4;
    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst;
    logic cpu_cyc, cpu_stb, cpu_we, cpu_ack;
    logic [W-1:0] hit_vec, valid_vec, way_write, valid_write, dirty_write;
    logic victim_dirty, plru_write, valid_in, dirty_in;
    logic [W-2:0] plru_out, plru_in;
    logic [1:0] victim_way, datainmux_sel;
    logic memaddrmux_sel, mem_cyc, mem_stb, mem_we, mem_ack, mem_rty;
    logic [26:0] outs;

    logic cpu_cyc_8, cpu_stb_8, cpu_we_8, cpu_ack_8;
    logic [7:0] hit_vec_8, valid_vec_8, way_write_8, valid_write_8, dirty_write_8;
    logic victim_dirty_8, plru_write_8, valid_in_8, dirty_in_8;
    logic [6:0] plru_out_8, plru_in_8;
    logic [2:0] victim_way_8;
    logic [1:0] datainmux_sel_8;
    logic memaddrmux_sel_8, mem_cyc_8, mem_stb_8, mem_we_8, mem_ack_8, mem_rty_8;

`ifdef PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
    logic [31:0] hit_count_8, miss_count_8, wb_count_8;
`endif

    int cmp = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign outs = {cpu_ack, plru_in, plru_write, victim_way, way_write, valid_write,
                   valid_in, dirty_write, dirty_in, datainmux_sel, memaddrmux_sel,
                   mem_cyc, mem_stb, mem_we};

    l2cache_control_nway #(.WAYS(4), .RTY_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we),
        .cpu_ack(cpu_ack), .hit_vec(hit_vec), .valid_vec(valid_vec),
        .victim_dirty(victim_dirty), .plru_out(plru_out), .plru_in(plru_in),
        .plru_write(plru_write), .victim_way(victim_way), .way_write(way_write),
        .valid_write(valid_write), .valid_in(valid_in), .dirty_write(dirty_write),
        .dirty_in(dirty_in), .datainmux_sel(datainmux_sel),
        .memaddrmux_sel(memaddrmux_sel), .mem_cyc(mem_cyc), .mem_stb(mem_stb),
        .mem_we(mem_we), .mem_ack(mem_ack), .mem_rty(mem_rty)
`ifdef PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    l2cache_control_nway #(.WAYS(8), .RTY_GAP(GAP)) dut8 (
        .clk(clk), .rst(rst), .cpu_cyc(cpu_cyc_8), .cpu_stb(cpu_stb_8), .cpu_we(cpu_we_8),
        .cpu_ack(cpu_ack_8), .hit_vec(hit_vec_8), .valid_vec(valid_vec_8),
        .victim_dirty(victim_dirty_8), .plru_out(plru_out_8), .plru_in(plru_in_8),
        .plru_write(plru_write_8), .victim_way(victim_way_8), .way_write(way_write_8),
        .valid_write(valid_write_8), .valid_in(valid_in_8), .dirty_write(dirty_write_8),
        .dirty_in(dirty_in_8), .datainmux_sel(datainmux_sel_8),
        .memaddrmux_sel(memaddrmux_sel_8), .mem_cyc(mem_cyc_8), .mem_stb(mem_stb_8),
        .mem_we(mem_we_8), .mem_ack(mem_ack_8), .mem_rty(mem_rty_8)
`ifdef PERF_CNT_EN
        , .hit_count(hit_count_8), .miss_count(miss_count_8), .wb_count(wb_count_8)
`endif
    );

    // Reference PLRU: heap-numbered leaves, walk up from the leaf to the root.
    function automatic logic [14:0] m_touch(int ways, logic [14:0] pl, int w);
        int c = w + ways - 1;
        int p;
        while (c > 0) begin
            p = (c - 1) / 2;
            pl[p] = (c == 2 * p + 1);
            c = p;
        end
        return pl;
    endfunction

    function automatic int m_victim(int ways, logic [15:0] vv, logic [14:0] pl);
        int n = 0;
        for (int i = 0; i < ways; i++) if (!vv[i]) return i;
        while (n < ways - 1) n = 2 * n + 1 + int'(pl[n]);
        return n - (ways - 1);
    endfunction

    function automatic int m_lowest(logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        cmp++;
        if (outs !== 27'd0) begin
            bad++;
            $display("FAIL reset_outs got %h want 0", outs);
        end
        cmp++;
        if ({cpu_ack_8, mem_cyc_8, victim_way_8, plru_write_8} !== 6'd0) begin
            bad++;
            $display("FAIL reset_outs8 got %b want 0", {cpu_ack_8, mem_cyc_8, victim_way_8});
        end
`ifdef PERF_CNT_EN
        cmp++;
        if ({hit_count, miss_count, wb_count} !== 96'd0) begin
            bad++;
            $display("FAIL reset_perf got %h/%h/%h want 0", hit_count, miss_count, wb_count);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_no_req;
        @(negedge clk);
        cpu_cyc = 1'b1;
        cpu_stb = 1'b0;
        hit_vec = 4'b0001;
        #1;
        cmp++;
        if ({cpu_ack, plru_write, mem_cyc} !== 3'b000) begin
            bad++;
            $display("FAIL no_req got %b want 000", {cpu_ack, plru_write, mem_cyc});
        end
        @(negedge clk);
        cpu_cyc = 1'b0;
        hit_vec = '0;
    endtask

    task automatic test_hit(input logic [3:0] hv, input logic [2:0] pl, input logic we);
        int w;
        logic [14:0] e;
        logic [3:0] oh;
        @(negedge clk);
        cpu_cyc = 1'b1;
        cpu_stb = 1'b1;
        cpu_we = we;
        hit_vec = hv;
        valid_vec = 4'b1111;
        plru_out = pl;
        #1;
        w = m_lowest(16'(hv));
        e = m_touch(4, 15'(pl), w);
        oh = we ? 4'(1 << w) : 4'd0;
        cmp++;
        if ({cpu_ack, plru_write} !== 2'b11) begin
            bad++;
            $display("FAIL hit_ack got %b want 11", {cpu_ack, plru_write});
        end
        cmp++;
        if (plru_in !== e[2:0]) begin
            bad++;
            $display("FAIL hit_plru hv=%b pl=%b got %b want %b", hv, pl, plru_in, e[2:0]);
        end
        cmp++;
        if ({way_write, valid_write, dirty_write} !== {oh, oh, oh}) begin
            bad++;
            $display("FAIL hit_strobes got %b/%b/%b want %b", way_write, valid_write,
                     dirty_write, oh);
        end
        cmp++;
        if ({valid_in, dirty_in, datainmux_sel, mem_cyc} !== {we, we, 1'b0, we, 1'b0}) begin
            bad++;
            $display("FAIL hit_ctrl got %b want %b", {valid_in, dirty_in, datainmux_sel, mem_cyc},
                     {we, we, 1'b0, we, 1'b0});
        end
        @(negedge clk);
        cpu_cyc = 1'b0;
        cpu_stb = 1'b0;
        cpu_we = 1'b0;
        hit_vec = '0;
    endtask

    task automatic test_miss(input logic [3:0] vv, input logic [2:0] pl, input logic dirty,
                             input logic rty_wb, input logic rty_al, input logic both,
                             input logic drop);
        int v;
        logic wb;
        logic [2:0] pl2;
        logic [14:0] e;
        @(negedge clk);
        cpu_cyc = 1'b1;
        cpu_stb = 1'b1;
        cpu_we = 1'($urandom);
        hit_vec = '0;
        valid_vec = vv;
        plru_out = pl;
        victim_dirty = dirty;
        mem_ack = 1'b0;
        mem_rty = 1'b0;
        #1;
        v = m_victim(4, 16'(vv), 15'(pl));
        wb = vv[v] && dirty;
        cmp++;
        if ({cpu_ack, plru_write, mem_cyc, way_write} !== 7'd0) begin
            bad++;
            $display("FAIL miss_idle got %b want 0", {cpu_ack, plru_write, mem_cyc, way_write});
        end
        @(negedge clk);
        plru_out = 3'($urandom);
        valid_vec = 4'($urandom);
        victim_dirty = 1'($urandom);
        if (drop) begin
            cpu_cyc = 1'b0;
            cpu_stb = 1'b0;
        end
        #1;
        cmp++;
        if (victim_way !== 2'(v)) begin
            bad++;
            $display("FAIL miss_victim vv=%b pl=%b got %0d want %0d", vv, pl, victim_way, v);
        end
        if (wb) begin
            if (rty_wb) begin
                cmp++;
                if ({mem_cyc, mem_stb, mem_we, memaddrmux_sel} !== 4'b1111) begin
                    bad++;
                    $display("FAIL wb_pre_rty got %b want 1111",
                             {mem_cyc, mem_stb, mem_we, memaddrmux_sel});
                end
                mem_rty = 1'b1;
                @(negedge clk);
                mem_rty = 1'b0;
                for (int k = 0; k < GAP; k++) begin
                    #1;
                    cmp++;
                    if ({mem_cyc, mem_stb, mem_we} !== 3'b000) begin
                        bad++;
                        $display("FAIL wb_rty_gap k=%0d got %b want 000", k,
                                 {mem_cyc, mem_stb, mem_we});
                    end
                    @(negedge clk);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                #1;
                cmp++;
                if ({mem_cyc, mem_stb, mem_we, memaddrmux_sel, way_write} !== 8'b1111_0000) begin
                    bad++;
                    $display("FAIL wb_wait got %b want 11110000",
                             {mem_cyc, mem_stb, mem_we, memaddrmux_sel, way_write});
                end
                @(negedge clk);
            end
            #1;
            cmp++;
            if ({mem_cyc, mem_we, memaddrmux_sel} !== 3'b111) begin
                bad++;
                $display("FAIL wb_state got %b want 111", {mem_cyc, mem_we, memaddrmux_sel});
            end
            mem_ack = 1'b1;
            mem_rty = both;
            #1;
            cmp++;
            if ({way_write, plru_write, cpu_ack} !== 6'd0) begin
                bad++;
                $display("FAIL wb_ack_nowrite got %b want 0", {way_write, plru_write, cpu_ack});
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rty = 1'b0;
            #1;
            cmp++;
            if ({mem_cyc, mem_stb, mem_we, memaddrmux_sel} !== 4'b0000) begin
                bad++;
                $display("FAIL strobe got %b want 0000",
                         {mem_cyc, mem_stb, mem_we, memaddrmux_sel});
            end
            @(negedge clk);
        end
        #1;
        cmp++;
        if ({mem_cyc, mem_stb, mem_we, memaddrmux_sel, datainmux_sel, way_write}
            !== 10'b1100_00_0000) begin
            bad++;
            $display("FAIL alloc_state got %b want 1100000000",
                     {mem_cyc, mem_stb, mem_we, memaddrmux_sel, datainmux_sel, way_write});
        end
        if (rty_al) begin
            mem_rty = 1'b1;
            @(negedge clk);
            mem_rty = 1'b0;
            for (int k = 0; k < GAP; k++) begin
                plru_out = 3'($urandom);
                valid_vec = 4'($urandom);
                #1;
                cmp++;
                if ({mem_cyc, mem_stb} !== 2'b00) begin
                    bad++;
                    $display("FAIL al_rty_gap k=%0d got %b want 00", k, {mem_cyc, mem_stb});
                end
                @(negedge clk);
            end
            #1;
            cmp++;
            if ({mem_cyc, mem_stb, mem_we, victim_way} !== {3'b110, 2'(v)}) begin
                bad++;
                $display("FAIL al_reissue got %b want %b", {mem_cyc, mem_stb, mem_we, victim_way},
                         {3'b110, 2'(v)});
            end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        plru_out = 3'($urandom);
        pl2 = plru_out;
        mem_ack = 1'b1;
        mem_rty = both;
        #1;
        e = m_touch(4, 15'(pl2), v);
        cmp++;
        if ({way_write, valid_write, dirty_write} !== {3{4'(1 << v)}}) begin
            bad++;
            $display("FAIL fill_strobes got %b/%b/%b want %b", way_write, valid_write,
                     dirty_write, 4'(1 << v));
        end
        cmp++;
        if ({valid_in, dirty_in, plru_write, cpu_ack, datainmux_sel} !== 6'b101000) begin
            bad++;
            $display("FAIL fill_ctrl got %b want 101000",
                     {valid_in, dirty_in, plru_write, cpu_ack, datainmux_sel});
        end
        cmp++;
        if (plru_in !== e[2:0]) begin
            bad++;
            $display("FAIL fill_plru got %b want %b", plru_in, e[2:0]);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rty = 1'b0;
        hit_vec = 4'(1 << v);
        #1;
        cmp++;
        if ({cpu_ack, mem_cyc} !== {~drop, 1'b0}) begin
            bad++;
            $display("FAIL post_fill got %b want %b", {cpu_ack, mem_cyc}, {~drop, 1'b0});
        end
        @(negedge clk);
        cpu_cyc = 1'b0;
        cpu_stb = 1'b0;
        cpu_we = 1'b0;
        hit_vec = '0;
    endtask

    task automatic test_reset_mid_wb;
        @(negedge clk);
        cpu_cyc = 1'b1;
        cpu_stb = 1'b1;
        hit_vec = '0;
        valid_vec = 4'b1111;
        plru_out = 3'($urandom);
        victim_dirty = 1'b1;
        @(negedge clk);
        #1;
        cmp++;
        if ({mem_cyc, mem_we, memaddrmux_sel} !== 3'b111) begin
            bad++;
            $display("FAIL rst_wb_enter got %b want 111", {mem_cyc, mem_we, memaddrmux_sel});
        end
        rst = 1'b1;
        cpu_cyc = 1'b0;
        cpu_stb = 1'b0;
        victim_dirty = 1'b0;
        @(negedge clk);
        #1;
        cmp++;
        if (outs !== 27'd0) begin
            bad++;
            $display("FAIL rst_mid_wb got %h want 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        cpu_cyc = 1'b1;
        cpu_stb = 1'b1;
        hit_vec = 4'b0010;
        #1;
        cmp++;
        if ({cpu_ack, mem_cyc} !== 2'b10) begin
            bad++;
            $display("FAIL rst_then_hit got %b want 10", {cpu_ack, mem_cyc});
        end
        @(negedge clk);
        cpu_cyc = 1'b0;
        cpu_stb = 1'b0;
        hit_vec = '0;
    endtask

    task automatic test_ways8;
        logic [14:0] e;
        int v;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            cpu_cyc_8 = 1'b1;
            cpu_stb_8 = 1'b1;
            hit_vec_8 = 8'(($urandom << w) | (1 << w));
            plru_out_8 = 7'($urandom);
            #1;
            e = m_touch(8, 15'(plru_out_8), w);
            cmp++;
            if ({cpu_ack_8, plru_in_8} !== {1'b1, e[6:0]}) begin
                bad++;
                $display("FAIL w8_hit way=%0d got %b want %b", w, {cpu_ack_8, plru_in_8},
                         {1'b1, e[6:0]});
            end
        end
        @(negedge clk);
        hit_vec_8 = '0;
        valid_vec_8 = 8'hFF;
        victim_dirty_8 = 1'b0;
        plru_out_8 = 7'($urandom);
        v = m_victim(8, 16'(valid_vec_8), 15'(plru_out_8));
        @(negedge clk);
        #1;
        cmp++;
        if ({victim_way_8, mem_cyc_8, mem_we_8} !== {3'(v), 2'b10}) begin
            bad++;
            $display("FAIL w8_victim got %b want %b", {victim_way_8, mem_cyc_8, mem_we_8},
                     {3'(v), 2'b10});
        end
        mem_ack_8 = 1'b1;
        @(negedge clk);
        mem_ack_8 = 1'b0;
        cpu_cyc_8 = 1'b0;
        cpu_stb_8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {cpu_cyc, cpu_stb, cpu_we, victim_dirty, mem_ack, mem_rty} = '0;
        hit_vec = '0;
        valid_vec = '0;
        plru_out = '0;
        {cpu_cyc_8, cpu_stb_8, cpu_we_8, victim_dirty_8, mem_ack_8, mem_rty_8} = '0;
        hit_vec_8 = '0;
        valid_vec_8 = '0;
        plru_out_8 = '0;

        test_reset;
        test_no_req;
        test_hit(4'b0001, 3'b000, 1'b0);
        test_hit(4'b0100, 3'($urandom), 1'b1);
        for (int i = 0; i < 20; i++)
            test_hit(4'($urandom_range(1, 15)), 3'($urandom), 1'($urandom));
        test_miss(4'b1011, 3'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        test_miss(4'b1111, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        test_miss(4'b1111, 3'($urandom), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        test_miss(4'b1111, 3'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++)
            test_miss(4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom));
        test_reset_mid_wb;
        test_ways8;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
